// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples the
// synchronized rows, debounces press and release, and strobes the accepted key.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [1:0] row_index,
    output logic [1:0] col_index,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       col_ptr_q;
    logic [3:0]       cols_q;
    logic [1:0]       cap_row_q;
    logic [1:0]       cap_col_q;
    logic [1:0]       row_index_q;
    logic [1:0]       col_index_q;
    logic             key_valid_q;
    logic             key_held_q;
    logic [3:0]       rows_meta_q;
    logic [3:0]       rows_s_q;

    logic [1:0] col_ptr_d;
    logic       cap_pressed;

    function automatic logic [3:0] col_mask(input logic [1:0] ptr);
        return ~(4'b0001 << ptr);
    endfunction

    // Lowest-numbered low row wins when several rows are low in one column.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign col_ptr_d   = col_ptr_q + 2'd1;
    assign cap_pressed = ~rows_s_q[cap_row_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_meta_q <= 4'b1111;
            rows_s_q    <= 4'b1111;
        end else begin
            rows_meta_q <= rows;
            rows_s_q    <= rows_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_ptr_q   <= 2'd0;
            cols_q      <= 4'b1110;
            row_index_q <= 2'd0;
            col_index_q <= 2'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= '0;
                        if (rows_s_q == 4'b1111) begin
                            col_ptr_q <= col_ptr_d;
                            cols_q    <= col_mask(col_ptr_d);
                        end else begin
                            cap_row_q <= lowest_low(rows_s_q);
                            cap_col_q <= col_ptr_q;
                            state_q   <= DEBOUNCE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (!cap_pressed) begin
                        cnt_q   <= '0;
                        state_q <= SCAN;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q       <= '0;
                        state_q     <= HELD;
                        row_index_q <= cap_row_q;
                        col_index_q <= cap_col_q;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    cnt_q <= '0;
                    if (!cap_pressed) state_q <= RELEASE;
                end
                RELEASE: begin
                    // A row that drops again is a bounce: back to HELD, no new strobe.
                    if (cap_pressed) begin
                        cnt_q   <= '0;
                        state_q <= HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q      <= '0;
                        state_q    <= SCAN;
                        key_held_q <= 1'b0;
                        col_ptr_q  <= col_ptr_d;
                        cols_q     <= col_mask(col_ptr_d);
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign cols      = cols_q;
    assign row_index = row_index_q;
    assign col_index = col_index_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
